// File: rtl/term_cursor_ctrl_pkg.sv
// Shared constants for the terminal cursor controller: FSM encodings, character codes, screen geometry.
// Pure declarations, no logic, no latency.
// No flow control of its own.
package term_cursor_ctrl_pkg;

    // Request sequencer states. Plain constants rather than an enum so the
    // encoding stays stable for older tooling that probes the state register.
    localparam logic [2:0] ST_BOOT      = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_CLS_REQ   = 3'd2;
    localparam logic [2:0] ST_ROW_REQ   = 3'd3;
    localparam logic [2:0] ST_STAT_REQ  = 3'd4;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd5;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

    // Action taken once the init engine returns to idle.
    localparam logic [1:0] FOLLOW_NONE = 2'd0;
    localparam logic [1:0] FOLLOW_STAT = 2'd1;

    // Control character codes understood by the cursor logic.
    localparam logic [7:0] CHAR_NUL = 8'h00;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_VT  = 8'h0B;
    localparam logic [7:0] CHAR_FF  = 8'h0C;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_DC2 = 8'h12;

    // Screen geometry: 80 columns, logical text rows 0..30, status row sits
    // one physical row below the last text row (31 rows past scrollRow).
    localparam logic [6:0] MAXCOL            = 7'd79;
    localparam logic [4:0] LAST_TEXT_ROW     = 5'd30;
    localparam logic [4:0] STATUS_ROW_OFFSET = 5'd31;

    // Attributes handed to the init engine with every CLS/ROW request.
    typedef struct packed {
        logic       row_only;
        logic       sequential;
        logic [4:0] row;
        logic [6:0] col;
    } init_req_t;

    // Glyphs are the 7-bit printable ASCII range; everything else is a command or ignored.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/init_req_seq.sv
// Init-engine request sequencer: one-cycle CLS/ROW/STAT strobes, busy/idle handshake, follow-on status redraw.
// Strobe is driven in the cycle the REQ state is entered; one WAIT_BUSY cycle, then waits for engine idle.
// Holds off new characters (in_ready_o low) whenever not in IDLE or the engine is busy.
module init_req_seq
    import term_cursor_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic initStateIsIdle_i,
    input  logic start_cls_i,
    input  logic start_row_i,
    input  logic follow_stat_i,
    output logic boot_o,
    output logic enter_idle_o,
    output logic in_ready_o,
    output logic init_enable_o,
    output logic update_status_row_o
);

    logic [2:0] state_q, state_d;
    logic [1:0] follow_q, follow_d;
    logic       in_ready_q;
    logic       init_enable_q;
    logic       update_status_row_q;

    // Next-state logic; the follow-on register remembers whether a status redraw is owed.
    always_comb begin
        state_d  = state_q;
        follow_d = follow_q;
        case (state_q)
            ST_BOOT: begin
                // Power-up behaves exactly like a form feed.
                state_d  = ST_CLS_REQ;
                follow_d = FOLLOW_STAT;
            end
            ST_IDLE: begin
                if (start_cls_i) begin
                    state_d  = ST_CLS_REQ;
                    follow_d = follow_stat_i ? FOLLOW_STAT : FOLLOW_NONE;
                end else if (start_row_i) begin
                    state_d  = ST_ROW_REQ;
                    follow_d = follow_stat_i ? FOLLOW_STAT : FOLLOW_NONE;
                end
            end
            ST_CLS_REQ, ST_ROW_REQ, ST_STAT_REQ: begin
                // The engine only drops idle one cycle after the strobe, so
                // skip a cycle before trusting initStateIsIdle.
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (initStateIsIdle_i) begin
                    if (follow_q == FOLLOW_STAT) begin
                        state_d  = ST_STAT_REQ;
                        follow_d = FOLLOW_NONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_BOOT;
                follow_d = FOLLOW_NONE;
            end
        endcase
    end

    // State plus registered strobes, decoded from the next state so each strobe lines up with its REQ state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q             <= ST_BOOT;
            follow_q            <= FOLLOW_NONE;
            in_ready_q          <= 1'b0;
            init_enable_q       <= 1'b1;
            update_status_row_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            follow_q            <= follow_d;
            in_ready_q          <= (state_d == ST_IDLE) && initStateIsIdle_i;
            init_enable_q       <= !((state_d == ST_CLS_REQ) || (state_d == ST_ROW_REQ));
            update_status_row_q <= (state_d == ST_STAT_REQ);
        end
    end

    assign boot_o              = (state_q == ST_BOOT);
    assign enter_idle_o        = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign in_ready_o          = in_ready_q;
    assign init_enable_o       = init_enable_q;
    assign update_status_row_o = update_status_row_q;

endmodule

// File: rtl/term_cursor_ctrl.sv
// Terminal cursor/scroll controller: writes glyphs at the cursor, tracks scroll offset, issues init-engine requests.
// Glyph write and cursor update one cycle after acceptance; requests strobe one cycle after acceptance.
// inReady is low outside IDLE or while the init engine is busy; printables stream at one per cycle.
module term_cursor_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inValid,
    input  logic [7:0]  inData,
    output logic        inReady,
    input  logic        initStateIsIdle,
    output logic        initEnable,
    output logic        initRowOnly,
    output logic        initSequential,
    output logic [4:0]  initRowRow,
    output logic [6:0]  initRowCol,
    output logic        updateStatusRow,
    output logic [4:0]  scrollRow,
    output logic        wrEn,
    output logic [11:0] wrAddress,
    output logic [6:0]  wrData,
    output logic [4:0]  cursorRow,
    output logic [6:0]  cursorCol
);

    import term_cursor_ctrl_pkg::*;

    logic        accept;
    logic        seq_boot;
    logic        seq_enter_idle;
    logic        start_cls;
    logic        start_row;
    logic        follow_stat;
    logic        newline;
    logic [4:0]  phys_row;

    logic [4:0]  cursor_row_q, cursor_row_d;
    logic [6:0]  cursor_col_q, cursor_col_d;
    logic [4:0]  scroll_q, scroll_d;
    init_req_t   req_q, req_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [6:0]  wr_data_q, wr_data_d;

    init_req_seq u_seq (
        .clk                 (clk),
        .resetn              (resetn),
        .initStateIsIdle_i   (initStateIsIdle),
        .start_cls_i         (start_cls),
        .start_row_i         (start_row),
        .follow_stat_i       (follow_stat),
        .boot_o              (seq_boot),
        .enter_idle_o        (seq_enter_idle),
        .in_ready_o          (inReady),
        .init_enable_o       (initEnable),
        .update_status_row_o (updateStatusRow)
    );

    // inReady is only high in IDLE with the engine idle, so acceptance implies both.
    assign accept   = inValid && inReady;
    // Logical row maps onto the circular 32-row buffer through the scroll offset.
    assign phys_row = scroll_q + cursor_row_q;

    // Character decode: cursor movement, glyph writes and init-engine request set-up.
    always_comb begin
        cursor_row_d = cursor_row_q;
        cursor_col_d = cursor_col_q;
        scroll_d     = scroll_q;
        req_d        = req_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        start_cls    = 1'b0;
        start_row    = 1'b0;
        follow_stat  = 1'b0;
        newline      = 1'b0;

        if (seq_boot) begin
            // Boot clear: home cursor, no scroll, plain (non-test) fill.
            cursor_row_d = 5'd0;
            cursor_col_d = 7'd0;
            scroll_d     = 5'd0;
            req_d        = '0;
        end else if (accept) begin
            if (is_printable(inData)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {cursor_col_q, phys_row};
                wr_data_d = inData[6:0];
                if (cursor_col_q == MAXCOL) begin
                    cursor_col_d = 7'd0;
                    newline      = 1'b1;
                end else begin
                    cursor_col_d = cursor_col_q + 7'd1;
                end
            end else begin
                case (inData)
                    CHAR_CR: cursor_col_d = 7'd0;
                    CHAR_LF: newline = 1'b1;
                    CHAR_BS: begin
                        if (cursor_col_q != 7'd0) begin
                            cursor_col_d = cursor_col_q - 7'd1;
                        end
                    end
                    CHAR_VT: begin
                        // Erase to end of line from the cursor; no status redraw needed.
                        start_row = 1'b1;
                        req_d     = '{row_only: 1'b1, sequential: 1'b0,
                                      row: phys_row, col: cursor_col_q};
                    end
                    CHAR_FF, CHAR_DC2: begin
                        cursor_row_d = 5'd0;
                        cursor_col_d = 7'd0;
                        scroll_d     = 5'd0;
                        start_cls    = 1'b1;
                        follow_stat  = 1'b1;
                        req_d        = '{row_only: 1'b0, sequential: (inData == CHAR_DC2),
                                         row: 5'd0, col: 7'd0};
                    end
                    CHAR_NUL: ;
                    default: ;
                endcase
            end

            // Only the bottom text row scrolls; moving down within the text
            // area needs no erase because the row below was cleared when it
            // last scrolled into view (or by the full clear).
            if (newline) begin
                if (cursor_row_q < LAST_TEXT_ROW) begin
                    cursor_row_d = cursor_row_q + 5'd1;
                end else begin
                    scroll_d    = scroll_q + 5'd1;
                    start_row   = 1'b1;
                    follow_stat = 1'b1;
                    req_d       = '{row_only: 1'b1, sequential: 1'b0,
                                    row: scroll_d + LAST_TEXT_ROW, col: 7'd0};
                end
            end
        end else if (seq_enter_idle) begin
            // Request attributes are only meaningful while a request is in flight.
            req_d = '0;
        end
    end

    // Register all state and outputs; synchronous reset lands everything at home with the engine strobe idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cursor_row_q <= 5'd0;
            cursor_col_q <= 7'd0;
            scroll_q     <= 5'd0;
            req_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 12'd0;
            wr_data_q    <= 7'd0;
        end else begin
            cursor_row_q <= cursor_row_d;
            cursor_col_q <= cursor_col_d;
            scroll_q     <= scroll_d;
            req_q        <= req_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign initRowOnly    = req_q.row_only;
    assign initSequential = req_q.sequential;
    assign initRowRow     = req_q.row;
    assign initRowCol     = req_q.col;
    assign scrollRow      = scroll_q;
    assign wrEn           = wr_en_q;
    assign wrAddress      = wr_addr_q;
    assign wrData         = wr_data_q;
    assign cursorRow      = cursor_row_q;
    assign cursorCol      = cursor_col_q;

    // Status row follows the scroll offset; exported geometry kept next to its users.
    logic [4:0] status_phys_row;
    assign status_phys_row = scroll_q + STATUS_ROW_OFFSET;
    logic unused_status;
    assign unused_status = ^status_phys_row;

endmodule

// File: tb/tb_term_cursor_ctrl.sv
module tb_term_cursor_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inValid = 1'b0;
    logic [7:0]  inData = 8'h00;
    logic        inReady;
    logic        initStateIsIdle;
    logic        initEnable;
    logic        initRowOnly;
    logic        initSequential;
    logic [4:0]  initRowRow;
    logic [6:0]  initRowCol;
    logic        updateStatusRow;
    logic [4:0]  scrollRow;
    logic        wrEn;
    logic [11:0] wrAddress;
    logic [6:0]  wrData;
    logic [4:0]  cursorRow;
    logic [6:0]  cursorCol;

    always #5 clk = ~clk;

    term_cursor_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .inValid         (inValid),
        .inData          (inData),
        .inReady         (inReady),
        .initStateIsIdle (initStateIsIdle),
        .initEnable      (initEnable),
        .initRowOnly     (initRowOnly),
        .initSequential  (initSequential),
        .initRowRow      (initRowRow),
        .initRowCol      (initRowCol),
        .updateStatusRow (updateStatusRow),
        .scrollRow       (scrollRow),
        .wrEn            (wrEn),
        .wrAddress       (wrAddress),
        .wrData          (wrData),
        .cursorRow       (cursorRow),
        .cursorCol       (cursorCol)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Init engine stand-in: busy for a while after each strobe, aborted by reset.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (!resetn)                 busy_cnt <= 0;
        else if (!initEnable)        busy_cnt <= initRowOnly ? 8 : 40;
        else if (updateStatusRow)    busy_cnt <= 5;
        else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
    end
    assign initStateIsIdle = (busy_cnt == 0);

    // Scoreboard of expected DUT output events, in order.
    typedef struct packed {
        logic [1:0]  kind;
        logic [18:0] payload;
    } ev_t;
    localparam logic [1:0] EV_WR = 2'd1, EV_INIT = 2'd2, EV_STAT = 2'd3;
    ev_t exp_q[$];

    localparam logic [53:0] RST_VALS = 54'd1 << 52;
    logic [53:0] all_outs;
    assign all_outs = {inReady, initEnable, updateStatusRow, initRowOnly, initSequential, initRowRow,
                       initRowCol, scrollRow, wrEn, wrAddress, wrData, cursorRow, cursorCol};

    function automatic ev_t ev_init(input logic ro, input logic sq, input int row, input int col);
        logic [4:0] r;
        logic [6:0] c;
        r = 5'(row);
        c = 7'(col);
        return {EV_INIT, 5'd0, ro, sq, r, c};
    endfunction

    function automatic ev_t ev_stat();
        return {EV_STAT, 19'd0};
    endfunction

    // Reference cursor model.
    int m_row = 0, m_col = 0, m_scroll = 0;

    task automatic model_newline();
        if (m_row < 30) m_row++;
        else begin
            m_scroll = (m_scroll + 1) % 32;
            exp_q.push_back(ev_init(1'b1, 1'b0, (m_scroll + 30) % 32, 0));
            exp_q.push_back(ev_stat());
        end
    endtask

    task automatic model_char(input logic [7:0] c);
        logic [6:0] cc;
        logic [4:0] rr;
        if (c >= 8'h20 && c <= 8'h7E) begin
            cc = 7'(m_col);
            rr = 5'((m_scroll + m_row) % 32);
            exp_q.push_back({EV_WR, cc, rr, c[6:0]});
            if (m_col == 79) begin
                m_col = 0;
                model_newline();
            end else m_col++;
        end else begin
            case (c)
                8'h0D: m_col = 0;
                8'h0A: model_newline();
                8'h08: if (m_col > 0) m_col--;
                8'h0B: exp_q.push_back(ev_init(1'b1, 1'b0, (m_scroll + m_row) % 32, m_col));
                8'h0C, 8'h12: begin
                    m_row = 0; m_col = 0; m_scroll = 0;
                    exp_q.push_back(ev_init(1'b0, c == 8'h12, 0, 0));
                    exp_q.push_back(ev_stat());
                end
                default: ;
            endcase
        end
    endtask

    // Output monitor: pops the scoreboard on every write / request / status pulse.
    ev_t  mon_e;
    logic prev_en_low = 1'b0;
    logic prev_stat = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_en_low <= 1'b0;
            prev_stat   <= 1'b0;
        end else begin
            if (wrEn) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL write_event: got unexpected write addr=%h data=%h, required none", wrAddress, wrData);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e !== {EV_WR, wrAddress, wrData}) begin
                        failures++;
                        $display("FAIL write_event: got %h, required %h", {EV_WR, wrAddress, wrData}, mon_e);
                    end
                end
            end
            if (!initEnable) begin
                checks++;
                if (prev_en_low || updateStatusRow) begin
                    failures++;
                    $display("FAIL init_strobe_shape: prev_low=%b stat=%b, required 0 0", prev_en_low, updateStatusRow);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL init_event: got unexpected init request, required none");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e !== {EV_INIT, 5'd0, initRowOnly, initSequential, initRowRow, initRowCol}) begin
                        failures++;
                        $display("FAIL init_event: got ro=%b seq=%b row=%0d col=%0d, required %h", initRowOnly, initSequential, initRowRow, initRowCol, mon_e);
                    end
                end
            end
            if (updateStatusRow) begin
                checks++;
                if (prev_stat) begin
                    failures++;
                    $display("FAIL status_width: pulse longer than one cycle, required one");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL status_event: got unexpected status pulse, required none");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e !== ev_stat()) begin
                        failures++;
                        $display("FAIL status_event: got status pulse, required %h", mon_e);
                    end
                end
            end
            prev_en_low <= !initEnable;
            prev_stat   <= updateStatusRow;
        end
    end

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        while (!inReady && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!inReady) begin
            failures++;
            $display("FAIL send_timeout: inReady=%b, required 1", inReady);
        end else begin
            model_char(c);
            inValid = 1'b1;
            inData  = c;
            @(posedge clk);
            #1;
            inValid = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!inReady && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!inReady) begin
            failures++;
            $display("FAIL %s_ready_timeout: inReady=%b, required 1", name, inReady);
        end
    endtask

    task automatic test_reset();
        int n;
        resetn = 1'b0;
        inValid = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== RST_VALS) begin
            failures++;
            $display("FAIL reset_values: got %h, required %h", all_outs, RST_VALS);
        end
        m_row = 0; m_col = 0; m_scroll = 0;
        exp_q.push_back(ev_init(1'b0, 1'b0, 0, 0));
        exp_q.push_back(ev_stat());
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (initEnable !== 1'b0 || initSequential !== 1'b0) begin
            failures++;
            $display("FAIL boot_cls_strobe: initEnable=%b initSequential=%b, required 0 0", initEnable, initSequential);
        end
        @(posedge clk); #1;
        checks++;
        if (initEnable !== 1'b1) begin
            failures++;
            $display("FAIL boot_cls_width: initEnable=%b, required 1", initEnable);
        end
        n = 0;
        while (!updateStatusRow && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (updateStatusRow !== 1'b1 || inReady !== 1'b0) begin
            failures++;
            $display("FAIL boot_status: updateStatusRow=%b inReady=%b, required 1 0", updateStatusRow, inReady);
        end
        wait_ready("boot");
        checks++;
        if (exp_q.size() != 0 || cursorRow !== 5'd0 || cursorCol !== 7'd0 || scrollRow !== 5'd0) begin
            failures++;
            $display("FAIL boot_done: pending=%0d row=%0d col=%0d scroll=%0d, required 0 0 0 0", exp_q.size(), cursorRow, cursorCol, scrollRow);
        end
    endtask

    task automatic test_printable();
        send_char(8'h41);
        checks++;
        if (wrEn !== 1'b1 || wrAddress !== 12'h000 || wrData !== 7'h41) begin
            failures++;
            $display("FAIL print_A: wrEn=%b addr=%h data=%h, required 1 000 41", wrEn, wrAddress, wrData);
        end
        checks++;
        if (cursorCol !== 7'd1 || inReady !== 1'b1) begin
            failures++;
            $display("FAIL print_A_cursor: col=%0d inReady=%b, required 1 1", cursorCol, inReady);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        send_char(8'h0D);
        c0 = cyc;
        for (int i = 0; i < 80; i++) send_char(8'(8'h20 + (i % 95)));
        checks++;
        if (wrAddress !== 12'h9E0 || cursorRow !== 5'd1 || cursorCol !== 7'd0) begin
            failures++;
            $display("FAIL line_wrap: addr=%h row=%0d col=%0d, required 9e0 1 0", wrAddress, cursorRow, cursorCol);
        end
        checks++;
        if (cyc - c0 != 80) begin
            failures++;
            $display("FAIL back_to_back_rate: cycles=%0d, required 80", cyc - c0);
        end
    endtask

    task automatic test_scroll();
        for (int i = 0; i < 29; i++) send_char(8'h0A);
        checks++;
        if (cursorRow !== 5'd30 || scrollRow !== 5'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL lf_no_scroll: row=%0d scroll=%0d pending=%0d, required 30 0 0", cursorRow, scrollRow, exp_q.size());
        end
        send_char(8'h0A);
        checks++;
        if ({scrollRow, initEnable, initRowOnly, initRowRow, initRowCol, cursorRow, inReady} !==
            {5'd1, 1'b0, 1'b1, 5'd31, 7'd0, 5'd30, 1'b0}) begin
            failures++;
            $display("FAIL scroll_req: scroll=%0d en=%b ro=%b row=%0d col=%0d crow=%0d rdy=%b, required 1 0 1 31 0 30 0",
                     scrollRow, initEnable, initRowOnly, initRowRow, initRowCol, cursorRow, inReady);
        end
        wait_ready("scroll");
        checks++;
        if (initRowOnly !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL scroll_done: initRowOnly=%b pending=%0d, required 0 0", initRowOnly, exp_q.size());
        end
        send_char(8'h5A);
        checks++;
        if (wrAddress !== 12'h01F) begin
            failures++;
            $display("FAIL scrolled_write: addr=%h, required 01f", wrAddress);
        end
        send_char(8'h0A);
        wait_ready("scroll2");
        checks++;
        if (scrollRow !== 5'd2 || cursorRow !== 5'd30 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL scroll_wrap2: scroll=%0d row=%0d pending=%0d, required 2 30 0", scrollRow, cursorRow, exp_q.size());
        end
    endtask

    task automatic test_edit();
        send_char(8'h0D);
        send_char(8'h08);
        checks++;
        if (cursorCol !== 7'd0 || wrEn !== 1'b0 || inReady !== 1'b1) begin
            failures++;
            $display("FAIL bs_at_col0: col=%0d wrEn=%b rdy=%b, required 0 0 1", cursorCol, wrEn, inReady);
        end
        for (int i = 0; i < 40; i++) send_char(8'(8'h61 + (i % 26)));
        send_char(8'h08);
        checks++;
        if (cursorCol !== 7'd39) begin
            failures++;
            $display("FAIL bs_step: col=%0d, required 39", cursorCol);
        end
        send_char(8'h78);
        send_char(8'h0B);
        checks++;
        if ({initEnable, initRowOnly, initSequential, initRowCol, initRowRow} !== {1'b0, 1'b1, 1'b0, 7'd40, 5'd0}) begin
            failures++;
            $display("FAIL erase_line: en=%b ro=%b seq=%b col=%0d row=%0d, required 0 1 0 40 0",
                     initEnable, initRowOnly, initSequential, initRowCol, initRowRow);
        end
        wait_ready("erase_line");
        checks++;
        if (cursorCol !== 7'd40 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL erase_line_done: col=%0d pending=%0d, required 40 0", cursorCol, exp_q.size());
        end
    endtask

    task automatic test_fill();
        send_char(8'h12);
        checks++;
        if ({initEnable, initSequential, initRowOnly, scrollRow, cursorRow, cursorCol} !== {1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 7'd0}) begin
            failures++;
            $display("FAIL test_fill_req: en=%b seq=%b ro=%b scroll=%0d row=%0d col=%0d, required 0 1 0 0 0 0",
                     initEnable, initSequential, initRowOnly, scrollRow, cursorRow, cursorCol);
        end
        wait_ready("test_fill");
        send_char(8'h0C);
        checks++;
        if (initEnable !== 1'b0 || initSequential !== 1'b0) begin
            failures++;
            $display("FAIL form_feed_req: en=%b seq=%b, required 0 0", initEnable, initSequential);
        end
        wait_ready("form_feed");
    endtask

    task automatic test_ignored();
        logic [7:0] codes [4];
        codes[0] = 8'h00; codes[1] = 8'h7F; codes[2] = 8'hC1; codes[3] = 8'h1B;
        send_char(8'h61); send_char(8'h62); send_char(8'h63);
        for (int i = 0; i < 4; i++) begin
            send_char(codes[i]);
            checks++;
            if (cursorCol !== 7'd3 || cursorRow !== 5'd0 || wrEn !== 1'b0 || inReady !== 1'b1) begin
                failures++;
                $display("FAIL ignored_%h: col=%0d row=%0d wrEn=%b rdy=%b, required 3 0 0 1", codes[i], cursorCol, cursorRow, wrEn, inReady);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 31; i++) send_char(8'h0A);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        m_row = 0; m_col = 0; m_scroll = 0;
        @(posedge clk); #1;
        checks++;
        if (all_outs !== RST_VALS) begin
            failures++;
            $display("FAIL mid_reset_values: got %h, required %h", all_outs, RST_VALS);
        end
        exp_q.push_back(ev_init(1'b0, 1'b0, 0, 0));
        exp_q.push_back(ev_stat());
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (initEnable !== 1'b0 || initSequential !== 1'b0 || initRowOnly !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear: en=%b seq=%b ro=%b, required 0 0 0", initEnable, initSequential, initRowOnly);
        end
        wait_ready("mid_reset");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_printable();
        test_back_to_back();
        test_scroll();
        test_edit();
        test_fill();
        test_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
